// File: rtl/eqy_check_pkg.sv
// ---------------------------------------------------------------------------
// eqy_check_pkg
// Shared definitions for the equivalence checker: the FSM state encoding and
// the width of the beat counters exposed on the checker outputs.
// ---------------------------------------------------------------------------
package eqy_check_pkg;

   // Width of the beat counter and the captured mismatch index.
   localparam int CNT_W = 32;

   // Checker FSM states. IDLE waits for start, RUN accepts beats, PASS and
   // FAIL are terminal until the next start or reset.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PASS = 2'd2,
      FAIL = 2'd3
   } state_e;

endpackage

// File: rtl/equiv_checker_if.sv
// ---------------------------------------------------------------------------
// equiv_checker_if
// Beat interface carrying one sampled miter cycle into the checker.
//   in_valid : source has a beat (gold/gate/mask) on the bus
//   in_ready : checker accepts the beat this cycle
//   gold     : reference-design output
//   gate     : implementation output
//   mask     : per-bit compare enable, 0 = don't care
// Modports: master drives the beat, slave is the checker side.
// ---------------------------------------------------------------------------
interface equiv_checker_if #(
   parameter int WIDTH = 8
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] gold;
   logic [WIDTH-1:0] gate;
   logic [WIDTH-1:0] mask;

   modport master (
      output in_valid,
      output gold,
      output gate,
      output mask,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  gold,
      input  gate,
      input  mask,
      output in_ready
   );

endinterface

// File: rtl/eqy_masked_cmp.sv
// ---------------------------------------------------------------------------
// eqy_masked_cmp
// Purely combinational masked comparator. A beat mismatches when any bit that
// is enabled by mask differs between gold and gate; a zero mask never
// mismatches.
//   gold     : reference value
//   gate     : implementation value
//   mask     : per-bit compare enable
//   mismatch : 1 when ((gold ^ gate) & mask) != 0
// ---------------------------------------------------------------------------
module eqy_masked_cmp #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] gold,
   input  logic [WIDTH-1:0] gate,
   input  logic [WIDTH-1:0] mask,
   output logic             mismatch
);

   assign mismatch = |((gold ^ gate) & mask);

endmodule

// File: rtl/equiv_checker.sv
// ---------------------------------------------------------------------------
// equiv_checker
// Streams sampled miter cycles (gold vs gate under a mask) and decides whether
// MAX_CYCLES consecutive accepted beats all match. The first mismatching beat
// ends the run in FAIL and captures its index and data; MAX_CYCLES matching
// beats end it in PASS. Terminal states hold until start or reset.
//   clock      : sole clock, rising edge
//   resetn     : asynchronous active-low reset
//   start      : begin a new run from IDLE, PASS or FAIL
//   bus        : beat interface (slave side)
//   busy       : FSM in RUN
//   done       : FSM in PASS or FAIL
//   pass/fail  : FSM in PASS / FAIL
//   cycle      : matching beats accepted in the current run
//   fail_cycle : beat index of the first mismatch
//   fail_gold  : gold value of the first mismatch
//   fail_gate  : gate value of the first mismatch
// ---------------------------------------------------------------------------
module equiv_checker
   import eqy_check_pkg::*;
#(
   parameter int          WIDTH      = 8,
   parameter int unsigned MAX_CYCLES = 16
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             start,
   equiv_checker_if.slave   bus,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic [CNT_W-1:0] cycle,
   output logic [CNT_W-1:0] fail_cycle,
   output logic [WIDTH-1:0] fail_gold,
   output logic [WIDTH-1:0] fail_gate
);

   // Index of the beat that completes a passing run.
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_CYCLES - 1);

   state_e           state_q,      state_d;
   logic [CNT_W-1:0] cycle_q,      cycle_d;
   logic [CNT_W-1:0] fail_cycle_q, fail_cycle_d;
   logic [WIDTH-1:0] fail_gold_q,  fail_gold_d;
   logic [WIDTH-1:0] fail_gate_q,  fail_gate_d;
   logic             ready_q,      ready_d;
   logic             busy_q,       busy_d;
   logic             done_q,       done_d;
   logic             pass_q,       pass_d;
   logic             fail_q,       fail_d;

   logic             beat;
   logic             mismatch;

   eqy_masked_cmp #(
      .WIDTH (WIDTH)
   ) u_cmp (
      .gold     (bus.gold),
      .gate     (bus.gate),
      .mask     (bus.mask),
      .mismatch (mismatch)
   );

   // ready_q is high exactly while in RUN, so a beat offered in any other
   // state (including the cycle start is sampled) is never accepted.
   assign beat = bus.in_valid && ready_q;

   // Next-state and capture logic. The status flags are decoded from the
   // next state so that they, like in_ready, come straight out of flops and
   // change on the same edge as the state itself.
   always_comb begin
      state_d      = state_q;
      cycle_d      = cycle_q;
      fail_cycle_d = fail_cycle_q;
      fail_gold_d  = fail_gold_q;
      fail_gate_d  = fail_gate_q;

      case (state_q)
         IDLE, PASS, FAIL: begin
            if (start) begin
               state_d      = RUN;
               cycle_d      = '0;
               fail_cycle_d = '0;
               fail_gold_d  = '0;
               fail_gate_d  = '0;
            end
         end
         RUN: begin
            // start is deliberately ignored here; only a decision or reset
            // ends a run. A mismatch wins even on the last beat.
            if (beat) begin
               if (mismatch) begin
                  state_d      = FAIL;
                  fail_cycle_d = cycle_q;
                  fail_gold_d  = bus.gold;
                  fail_gate_d  = bus.gate;
               end else begin
                  cycle_d = cycle_q + 1'b1;
                  if (cycle_q == LAST_BEAT) begin
                     state_d = PASS;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ready_d = (state_d == RUN);
      busy_d  = (state_d == RUN);
      done_d  = (state_d == PASS) || (state_d == FAIL);
      pass_d  = (state_d == PASS);
      fail_d  = (state_d == FAIL);
   end

   // All checker state, including the decoded status outputs, in one
   // register bank so reset clears everything at once with no glitch path.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         cycle_q      <= '0;
         fail_cycle_q <= '0;
         fail_gold_q  <= '0;
         fail_gate_q  <= '0;
         ready_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cycle_q      <= cycle_d;
         fail_cycle_q <= fail_cycle_d;
         fail_gold_q  <= fail_gold_d;
         fail_gate_q  <= fail_gate_d;
         ready_q      <= ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         fail_q       <= fail_d;
      end
   end

   assign bus.in_ready = ready_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign fail         = fail_q;
   assign cycle        = cycle_q;
   assign fail_cycle   = fail_cycle_q;
   assign fail_gold    = fail_gold_q;
   assign fail_gate    = fail_gate_q;

endmodule

// File: tb/tb_equiv_checker.sv
// ---------------------------------------------------------------------------
// tb_equiv_checker
// Directed bench for equiv_checker with WIDTH=8, MAX_CYCLES=4. Inputs change
// on the falling edge; outputs are sampled on the falling edge, half a cycle
// after the rising edge that produced them.
// ---------------------------------------------------------------------------
module tb_equiv_checker;

   logic        clock = 1'b0;
   logic        resetn;
   logic        start;
   logic        busy;
   logic        done;
   logic        pass;
   logic        fail;
   logic [31:0] cycle;
   logic [31:0] fail_cycle;
   logic [7:0]  fail_gold;
   logic [7:0]  fail_gate;

   int n_compared   = 0;
   int n_mismatched = 0;

   equiv_checker_if #(.WIDTH(8)) bus_if ();

   equiv_checker #(
      .WIDTH      (8),
      .MAX_CYCLES (4)
   ) dut (
      .clock      (clock),
      .resetn     (resetn),
      .start      (start),
      .bus        (bus_if.slave),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .fail       (fail),
      .cycle      (cycle),
      .fail_cycle (fail_cycle),
      .fail_gold  (fail_gold),
      .fail_gate  (fail_gate)
   );

   // Free-running 10-unit clock.
   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_compared++;
      if (observed !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs on the falling edge.
   task automatic applyStimulus(input logic s, input logic v, input logic [7:0] g,
                                input logic [7:0] t, input logic [7:0] m);
      @(negedge clock);
      start           = s;
      bus_if.in_valid = v;
      bus_if.gold     = g;
      bus_if.gate     = t;
      bus_if.mask     = m;
   endtask

   // Status flags plus beat count; in_ready must track busy.
   task automatic checkStatus(input string tag, input logic b, input logic d,
                              input logic p, input logic f, input logic [31:0] c);
      checkOutput({tag, "_busy"},  32'(busy),            32'(b));
      checkOutput({tag, "_ready"}, 32'(bus_if.in_ready), 32'(b));
      checkOutput({tag, "_done"},  32'(done),            32'(d));
      checkOutput({tag, "_pass"},  32'(pass),            32'(p));
      checkOutput({tag, "_fail"},  32'(fail),            32'(f));
      checkOutput({tag, "_cycle"}, cycle,                c);
   endtask

   task automatic checkCapture(input string tag, input logic [31:0] fc,
                               input logic [7:0] fg, input logic [7:0] ft);
      checkOutput({tag, "_fail_cycle"}, fail_cycle,      fc);
      checkOutput({tag, "_fail_gold"},  32'(fail_gold),  32'(fg));
      checkOutput({tag, "_fail_gate"},  32'(fail_gate),  32'(ft));
   endtask

   initial begin
      resetn          = 1'b0;
      start           = 1'b0;
      bus_if.in_valid = 1'b0;
      bus_if.gold     = 8'h00;
      bus_if.gate     = 8'h00;
      bus_if.mask     = 8'h00;

      // Reset state
      #2;
      checkStatus("reset", 0, 0, 0, 0, 0);
      checkCapture("reset", 0, 8'h00, 8'h00);
      applyStimulus(0, 0, 8'h00, 8'h00, 8'h00);
      resetn = 1'b1;

      // Four matching beats -> PASS one edge after the last beat
      applyStimulus(1, 0, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'hA5, 8'hA5, 8'hFF);
      applyStimulus(0, 1, 8'hA5, 8'hA5, 8'hFF);
      checkStatus("t1_pre", 1, 0, 0, 0, 3);
      applyStimulus(0, 0, 8'h00, 8'h00, 8'h00);
      checkStatus("t1_pass", 0, 1, 1, 0, 4);

      // Mismatch on beat 2 -> FAIL with captured data
      applyStimulus(1, 0, 8'h00, 8'h00, 8'h00);
      applyStimulus(0, 1, 8'hA5, 8'hA5, 8'hFF);
      checkStatus("t2_start", 1, 0, 0, 0, 0);
      applyStimulus(0, 1, 8'hA5, 8'hA5, 8'hFF);
      applyStimulus(0, 1, 8'h10, 8'h11, 8'hFF);
      applyStimulus(0, 0, 8'h00, 8'h00, 8'h00);
      checkStatus("t2_fail", 0, 1, 0, 1, 2);
      checkCapture("t2_fail", 2, 8'h10, 8'h11);
      // Beats offered in FAIL are ignored and captures hold
      applyStimulus(0, 1, 8'hFF, 8'h00, 8'hFF);
      applyStimulus(0, 1, 8'hFF, 8'h00, 8'hFF);
      checkStatus("t2_hold", 0, 1, 0, 1, 2);
      checkCapture("t2_hold", 2, 8'h10, 8'h11);

      // Mismatch on the last beat at bit 7 -> FAIL
      applyStimulus(1, 0, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'h5A, 8'h5A, 8'hFF);
      applyStimulus(0, 1, 8'h80, 8'h00, 8'hFF);
      applyStimulus(0, 0, 8'h00, 8'h00, 8'h00);
      checkStatus("t3_fail", 0, 1, 0, 1, 3);
      checkCapture("t3_fail", 3, 8'h80, 8'h00);

      // Same last beat with bit 7 masked off -> PASS
      applyStimulus(1, 0, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'h5A, 8'h5A, 8'hFF);
      applyStimulus(0, 1, 8'h80, 8'h00, 8'h7F);
      applyStimulus(0, 0, 8'h00, 8'h00, 8'h00);
      checkStatus("t3_pass", 0, 1, 1, 0, 4);
      checkCapture("t3_pass", 0, 8'h00, 8'h00);

      // Asynchronous reset mid-run
      applyStimulus(1, 0, 8'h00, 8'h00, 8'h00);
      applyStimulus(0, 1, 8'hC3, 8'hC3, 8'hFF);
      applyStimulus(0, 1, 8'hC3, 8'hC3, 8'hFF);
      applyStimulus(0, 0, 8'h00, 8'h00, 8'h00);
      checkStatus("t4_run", 1, 0, 0, 0, 2);
      #2;
      resetn = 1'b0;
      #1;
      checkStatus("t4_async", 0, 0, 0, 0, 0);
      checkCapture("t4_async", 0, 8'h00, 8'h00);
      applyStimulus(0, 1, 8'hFF, 8'h00, 8'hFF);
      resetn = 1'b1;
      // Valid held high in IDLE, then start with a mismatching beat present
      applyStimulus(0, 1, 8'hFF, 8'h00, 8'hFF);
      checkStatus("t4_idle", 0, 0, 0, 0, 0);
      applyStimulus(1, 1, 8'hFF, 8'h00, 8'hFF);
      checkStatus("t4_idle2", 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 8'hA5, 8'hA5, 8'hFF);
      checkStatus("t4_start", 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'hA5, 8'hA5, 8'hFF);
      applyStimulus(0, 0, 8'h00, 8'h00, 8'h00);
      checkStatus("t4_pass", 0, 1, 1, 0, 4);

      // Zero mask counts as match; start during RUN is ignored
      applyStimulus(1, 0, 8'h00, 8'h00, 8'h00);
      applyStimulus(0, 1, 8'hFF, 8'h00, 8'h00);
      applyStimulus(1, 1, 8'hA5, 8'hA5, 8'hFF);
      checkStatus("t5_mask0", 1, 0, 0, 0, 1);
      applyStimulus(0, 1, 8'h3C, 8'hC3, 8'hFF);
      checkStatus("t5_nostart", 1, 0, 0, 0, 2);
      applyStimulus(0, 0, 8'h00, 8'h00, 8'h00);
      checkStatus("t5_fail", 0, 1, 0, 1, 2);
      checkCapture("t5_fail", 2, 8'h3C, 8'hC3);

      // Restart from FAIL clears captures; the concurrent beat is not taken
      applyStimulus(1, 1, 8'hA5, 8'hA5, 8'hFF);
      applyStimulus(0, 0, 8'h00, 8'h00, 8'h00);
      checkStatus("t5_restart", 1, 0, 0, 0, 0);
      checkCapture("t5_restart", 0, 8'h00, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/equiv_checker.md
EQUIV_CHECKER -- requirements
Module: equiv_checker

Interface
REQ-001 Parameter WIDTH, default 8, width of each compared output vector.
REQ-002 Parameter MAX_CYCLES, default 16, number of matching beats that constitutes a pass; legal range 1..2^32-1.
REQ-003 clock  input  1  sole clock, all state updates on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begins a new check run when the FSM is in IDLE, PASS or FAIL.
REQ-006 in_valid  input  1  gold/gate/mask carry one sampled miter cycle.
REQ-007 in_ready  output  1  checker accepts a beat; a beat is in_valid && in_ready.
REQ-008 gold  input  WIDTH  reference-design output for the beat.
REQ-009 gate  input  WIDTH  implementation output for the beat.
REQ-010 mask  input  WIDTH  per-bit compare enable; 0 = don't care.
REQ-011 busy  output  1  FSM in RUN.
REQ-012 done  output  1  FSM in PASS or FAIL.
REQ-013 pass  output  1  FSM in PASS.
REQ-014 fail  output  1  FSM in FAIL.
REQ-015 cycle  output  32  number of matching beats accepted in the current run.
REQ-016 fail_cycle  output  32  beat index of the first mismatch.
REQ-017 fail_gold  output  WIDTH  gold value captured at the first mismatch.
REQ-018 fail_gate  output  WIDTH  gate value captured at the first mismatch.

Function
REQ-019 FSM states SHALL be IDLE, RUN, PASS, FAIL, one-hot-decoded onto busy/done/pass/fail, all registered.
REQ-020 in_ready SHALL be 1 only in RUN; beats offered in other states are ignored and not counted.
REQ-021 Mismatch SHALL be ((gold ^ gate) & mask) != 0, evaluated on the accepted beat only.
REQ-022 On an accepted mismatching beat: next state FAIL, fail_cycle <= cycle, fail_gold <= gold, fail_gate <= gate, cycle unchanged.
REQ-023 On an accepted matching beat: cycle <= cycle + 1; if cycle == MAX_CYCLES-1 next state PASS, else stay in RUN.
REQ-024 Latency: pass/fail SHALL assert on the first rising edge after the deciding beat; in_ready drops on that same edge.
REQ-025 A mismatch on the final (MAX_CYCLES-th) beat SHALL produce FAIL, never PASS.
REQ-026 mask == 0 on a beat SHALL count it as matching regardless of gold/gate.
REQ-027 start in IDLE/PASS/FAIL SHALL enter RUN next edge, clearing cycle, fail_cycle, fail_gold, fail_gate to 0.
REQ-028 start in RUN SHALL be ignored; a run ends only by PASS, FAIL or reset.
REQ-029 A beat presented in the same cycle as start from IDLE SHALL NOT be accepted (in_ready is 0).
REQ-030 PASS and FAIL SHALL hold with all capture outputs stable until start or reset.
REQ-031 cycle SHALL never exceed MAX_CYCLES; no wrap-around is reachable.

Reset
REQ-032 resetn low SHALL immediately force IDLE, in_ready=0, busy=done=pass=fail=0, cycle=fail_cycle=0, fail_gold=fail_gate=0.
REQ-033 Reset asserted mid-RUN SHALL discard the run with no pass/fail pulse; after release the block waits in IDLE for start.
REQ-034 Deassertion is assumed synchronised to clock upstream; the block adds no synchroniser.

Structure
REQ-035 Shared package eqy_check_pkg SHALL hold the state enum typedef (IDLE, RUN, PASS, FAIL) and the 32-bit cycle-count width constant.
REQ-036 The masked comparator SHALL be a sub-module eqy_masked_cmp (inputs gold, gate, mask; output mismatch), purely combinational.
REQ-037 All other logic SHALL live in equiv_checker; no memories, no second clock.

Verification
REQ-038 WIDTH=8, MAX_CYCLES=4; start; 4 beats gold=gate=8'hA5, mask=8'hFF -> pass=1 one edge after beat 4, cycle=4, fail=0.
REQ-039 Same config; beats 0,1 match, beat 2 gold=8'h10, gate=8'h11 -> fail=1, fail_cycle=2, fail_gold=8'h10, fail_gate=8'h11, cycle=2.
REQ-040 Beat 3 (last) mismatches at bit 7, mask=8'hFF -> FAIL, fail_cycle=3; repeat with mask=8'h7F -> PASS.
REQ-041 resetn pulsed low after 2 beats in RUN -> all outputs 0 asynchronously; subsequent start and 4 matching beats -> PASS, cycle=4.
REQ-042 In FAIL, assert start -> next edge busy=1, fail=0, fail_cycle=0, fail_gold=0; in_valid held high during IDLE is never accepted.
